rv32_register_file_mp: RTL and testbench



---
 rtl/rv32_register_file_mp.sv | 106 ++++++++++
 tb/tb_rv32_register_file_mp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_register_file_mp.sv
// Multi-port RV32 integer register file with registered reads and same-cycle write bypass.
// Define RF_SCOREBOARD_EN to build the busy-bit scoreboard; otherwise rd_busy is tied to 0.
module rv32_register_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NRD-1:0]      rd_busy
);

  logic [XLEN-1:0] r_mem       [NREGS];
  logic [AW-1:0]   w_wr_addr   [NWR];
  logic [XLEN-1:0] w_wr_data   [NWR];
  logic [AW-1:0]   w_rd_addr   [NRD];
  logic [XLEN-1:0] w_rd_next   [NRD];
  logic [XLEN-1:0] r_rd_data   [NRD];

  for (genvar gw = 0; gw < NWR; gw++) begin : g_wr_unpack
    assign w_wr_addr[gw] = wr_addr[gw*AW +: AW];
    assign w_wr_data[gw] = wr_data[gw*XLEN +: XLEN];
  end

  for (genvar gr = 0; gr < NRD; gr++) begin : g_rd_unpack
    assign w_rd_addr[gr]             = rd_addr[gr*AW +: AW];
    assign rd_data[gr*XLEN +: XLEN]  = r_rd_data[gr];
  end

  // Later ports are applied last, so the highest-indexed writer wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_mem[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (w_wr_addr[w] != '0)) r_mem[w_wr_addr[w]] <= w_wr_data[w];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      w_rd_next[p] = '0;
      if (w_rd_addr[p] != '0) begin
        w_rd_next[p] = r_mem[w_rd_addr[p]];
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (w_wr_addr[w] == w_rd_addr[p])) w_rd_next[p] = w_wr_data[w];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NRD; p++) r_rd_data[p] <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) r_rd_data[p] <= w_rd_next[p];
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_busy_after_clr;
  logic [NRD-1:0]   r_rd_busy;

  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (w_wr_addr[w] != '0)) w_clr_mask[w_wr_addr[w]] = 1'b1;
    end
    if (alloc_en && (alloc_addr != '0)) w_set_mask[alloc_addr] = 1'b1;
  end

  // Readers see clears but not this cycle's allocation, matching the bypassed data.
  assign w_busy_after_clr = r_busy & ~w_clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_rd_busy <= '0;
    end else begin
      r_busy <= (w_busy_after_clr | w_set_mask) & {{(NREGS-1){1'b1}}, 1'b0};
      for (int p = 0; p < NRD; p++) r_rd_busy[p] <= w_busy_after_clr[w_rd_addr[p]];
    end
  end

  assign rd_busy = r_rd_busy;
`else
  logic w_unused_alloc;
  assign w_unused_alloc = ^{alloc_en, alloc_addr};
  assign rd_busy        = '0;
`endif

endmodule

// File: tb/tb_rv32_register_file_mp.sv
// Scoreboard bench for rv32_register_file_mp (NRD=2, NWR=2); busy expectations follow RF_SCOREBOARD_EN.
module tb_rv32_register_file_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NRD-1:0]      rd_busy;

  always #5 clk = ~clk;

  rv32_register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .rd_busy(rd_busy)
  );

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    int                  tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks   = 0;
  int failures = 0;
  int cur_tag  = 0;

  // Reference state: architectural register values and outstanding-producer flags.
  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tag=%0d got=%h want=%h", name, cur_tag, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_alloc(input logic [AW-1:0] a);
    alloc_en = 1'b1;
    alloc_addr = a;
  endtask

  // Expected read = the register's value once this cycle's writes have landed;
  // expected busy = flag after this cycle's writebacks, before this cycle's allocation.
  task automatic step();
    exp_t e;
    logic [AW-1:0] a;
    e.tag = cur_tag;
    e.data = '0;
    e.busy = '0;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = wr_addr[w*AW +: AW];
        if (wr_en[w] && a != 0) begin
          m_mem[a] = wr_data[w*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        e.data[p*XLEN +: XLEN] = (a == 0) ? '0 : m_mem[a];
        e.busy[p] = SB ? m_busy[a] : 1'b0;
      end
      if (SB && alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*XLEN +: XLEN]),
              64'(mon_e.data[p*XLEN +: XLEN]));
        check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(mon_e.busy[p]));
      end
    end
  end

  logic [AW-1:0] ra;

  initial begin
    idle();
    @(negedge clk);
    cur_tag = 1;
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_rd_busy", 64'(rd_busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      set_wr(0, AW'($urandom_range(1, 31)), $urandom);
      set_wr(1, AW'($urandom_range(1, 31)), $urandom);
      set_rd(0, AW'($urandom_range(0, 31)));
      set_rd(1, AW'($urandom_range(0, 31)));
      set_alloc(AW'($urandom_range(1, 31)));
      step();
    end
    rst = 1'b0;
    idle(); set_rd(0, 5); set_rd(1, 5); step();

    cur_tag = 2;
    idle(); set_wr(0, 5, 32'hDEADBEEF); step();
    idle(); step();
    idle(); set_rd(0, 5); step();
    idle(); set_wr(0, 0, 32'h1234); step();
    idle(); set_rd(0, 0); set_rd(1, 0); step();

    cur_tag = 3;
    idle(); set_wr(1, 7, 32'h5A5A0000); step();
    idle(); set_wr(0, 7, 32'hA5A5A5A5); set_rd(0, 7); set_rd(1, 7); step();
    idle(); set_rd(0, 7); step();

    cur_tag = 4;
    idle(); set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(0, 3); set_rd(1, 3); step();
    idle(); set_rd(0, 3); set_rd(1, 3); step();

    cur_tag = 5;
    idle(); set_wr(0, 9, 32'h99); step();
    idle(); set_alloc(9); set_rd(0, 9); step();
    idle(); set_rd(0, 9); set_rd(1, 9); step();
    idle(); set_rd(1, 9); step();
    idle(); step();
    idle(); set_wr(0, 9, 32'h909); set_rd(0, 9); set_rd(1, 9); step();
    idle(); set_rd(0, 9); step();
    idle(); set_alloc(9); set_wr(1, 9, 32'h919); set_rd(0, 9); step();
    idle(); set_rd(0, 9); set_rd(1, 9); step();
    idle(); set_alloc(0); step();
    idle(); set_rd(0, 0); set_rd(1, 9); step();

    cur_tag = 6;
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 2) != 0)
          set_wr(w, AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)), $urandom);
      end
      for (int p = 0; p < NRD; p++)
        set_rd(p, AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) set_alloc(AW'($urandom_range(0, 7)));
      step();
    end

    cur_tag = 7;
    idle(); set_wr(0, 4, 32'hCAFEF00D); set_alloc(6); step();
    idle(); set_rd(0, 4); set_rd(1, 6); step();
    idle(); set_wr(0, 8, 32'h88888888); set_wr(1, 4, 32'h44); set_rd(0, 4); set_rd(1, 6);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rd_data", 64'(rd_data), 64'd0);
    check("async_rst_rd_busy", 64'(rd_busy), 64'd0);
    @(negedge clk);
    step();
    rst = 1'b0;
    idle(); step();
    for (int r = 0; r < NREGS; r += 2) begin
      idle();
      ra = AW'(r);
      set_rd(0, ra);
      ra = AW'(r + 1);
      set_rd(1, ra);
      step();
    end

    idle();
    step();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
